// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bundle between two requesters, the packet arbiter and the UART TX serializer.
// The master modport is the arbiter side. The slave modport is the producers/serializer side.
interface uart_tx_arbiter_if;
  logic [7:0] a_data;
  logic       a_valid;
  logic       a_last;
  logic       a_ready;
  logic [7:0] b_data;
  logic       b_valid;
  logic       b_last;
  logic       b_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       gnt_a;
  logic       gnt_b;
  logic       timeout;

  modport master (
    input  a_data, a_valid, a_last,
    output a_ready,
    input  b_data, b_valid, b_last,
    output b_ready,
    output tx_data, tx_valid,
    input  tx_ready,
    output gnt_a, gnt_b, timeout
  );

  modport slave (
    output a_data, a_valid, a_last,
    input  a_ready,
    output b_data, b_valid, b_last,
    input  b_ready,
    input  tx_data, tx_valid,
    output tx_ready,
    input  gnt_a, gnt_b, timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter sharing one UART TX serializer between requesters A and B.
// Each packet is prefixed with a source header byte. A stall timer revokes an abandoned grant.
//
// state | meaning
// IDLE  | no owner; waits for a request, then offers the winner's header byte
// HDR   | header byte offered, waiting for the serializer to take it
// PAY   | owner streams payload bytes until its last byte is taken or it stalls out
module uart_tx_arbiter #(
  parameter logic [7:0]  HDR_A   = 8'hA5,
  parameter logic [7:0]  HDR_B   = 8'hB5,
  parameter logic [15:0] TIMEOUT = 16'd60000
) (
  input logic CLK,
  input logic RST_N,
  uart_tx_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

  state_t      state;
  logic        rr;
  logic        last_q;
  logic        tx_valid_q;
  logic [7:0]  tx_data_q;
  logic        gnt_a_q;
  logic        gnt_b_q;
  logic        timeout_q;
  logic [15:0] stall_cnt;

  logic        sel_valid;
  logic        sel_last;
  logic [7:0]  sel_data;
  logic        pick_b;
  logic        stall_end;

  assign sel_valid = gnt_a_q ? bus.a_valid : bus.b_valid;
  assign sel_last  = gnt_a_q ? bus.a_last  : bus.b_last;
  assign sel_data  = gnt_a_q ? bus.a_data  : bus.b_data;
  // rr=1 means B is preferred
  assign pick_b    = bus.b_valid && (rr || !bus.a_valid);
  // Down-counter loaded with TIMEOUT; reaching 1 on a stall cycle means TIMEOUT stall cycles elapsed
  assign stall_end = (TIMEOUT != 16'd0) && (stall_cnt == 16'd1);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      rr         <= 1'b0;
      last_q     <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      gnt_a_q    <= 1'b0;
      gnt_b_q    <= 1'b0;
      timeout_q  <= 1'b0;
      stall_cnt  <= 16'd0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.a_valid || bus.b_valid) begin
            gnt_a_q    <= !pick_b;
            gnt_b_q    <= pick_b;
            tx_data_q  <= pick_b ? HDR_B : HDR_A;
            tx_valid_q <= 1'b1;
            stall_cnt  <= TIMEOUT;
            state      <= HDR;
          end
        end
        HDR: begin
          if (bus.tx_ready) begin
            tx_valid_q <= 1'b0;
            stall_cnt  <= TIMEOUT;
            state      <= PAY;
          end
        end
        PAY: begin
          if (tx_valid_q) begin
            if (bus.tx_ready) begin
              tx_valid_q <= 1'b0;
              if (last_q) begin
                gnt_a_q   <= 1'b0;
                gnt_b_q   <= 1'b0;
                rr        <= gnt_a_q;
                last_q    <= 1'b0;
                stall_cnt <= TIMEOUT;
                state     <= IDLE;
              end
            end
          end else if (sel_valid) begin
            tx_data_q  <= sel_data;
            tx_valid_q <= 1'b1;
            last_q     <= sel_last;
            stall_cnt  <= TIMEOUT;
          end else if (stall_end) begin
            gnt_a_q   <= 1'b0;
            gnt_b_q   <= 1'b0;
            rr        <= gnt_a_q;
            last_q    <= 1'b0;
            timeout_q <= 1'b1;
            stall_cnt <= TIMEOUT;
            state     <= IDLE;
          end else begin
            stall_cnt <= stall_cnt - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.gnt_a    = gnt_a_q;
  assign bus.gnt_b    = gnt_b_q;
  assign bus.timeout  = timeout_q;
  assign bus.a_ready  = gnt_a_q && !tx_valid_q;
  assign bus.b_ready  = gnt_b_q && !tx_valid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a cycle-vector table plus directed multi-cycle sequences.
module tb_uart_tx_arbiter;

  logic CLK;
  logic RST_N;
  uart_tx_arbiter_if bus ();

  uart_tx_arbiter #(.HDR_A(8'hA5), .HDR_B(8'hB5), .TIMEOUT(16'd20)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_chk = 0;
  int n_err = 0;

  // Serializer model: in auto mode it is busy ser_gap cycles after each accepted byte
  logic       ser_auto;
  logic       tx_ready_man;
  logic       ser_flush;
  int         ser_gap;
  int         ser_busy = 0;
  logic [7:0] txq[$];
  logic [1:0] gq[$];

  assign bus.tx_ready = ser_auto ? (ser_busy == 0) : tx_ready_man;

  always @(posedge CLK) begin
    if (ser_flush) ser_busy <= 0;
    else if (bus.tx_valid && bus.tx_ready) begin
      txq.push_back(bus.tx_data);
      gq.push_back({bus.gnt_a, bus.gnt_b});
      ser_busy <= ser_auto ? ser_gap : 0;
    end else if (ser_busy > 0) ser_busy <= ser_busy - 1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit to_b, input logic v, input logic [7:0] d, input logic l);
    if (to_b) begin
      bus.b_valid = v; bus.b_data = d; bus.b_last = l;
    end else begin
      bus.a_valid = v; bus.a_data = d; bus.a_last = l;
    end
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    ser_auto = 1'b0;
    tx_ready_man = 1'b0;
    ser_flush = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    ser_flush = 1'b0;
    txq.delete();
    gq.delete();
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
  endtask

  task automatic send_pkt(input bit to_b, input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input int n);
    logic [7:0] d;
    int t;
    for (int i = 0; i < n; i++) begin
      d = (i == 0) ? d0 : (i == 1) ? d1 : d2;
      drive(to_b, 1'b1, d, i == n - 1);
      t = 0;
      @(negedge CLK);
      while (!(to_b ? bus.b_ready : bus.a_ready) && t < 3000) begin
        @(negedge CLK);
        t++;
      end
      chk(to_b ? "b_ready_wait" : "a_ready_wait", int'(to_b ? bus.b_ready : bus.a_ready), 1);
      @(posedge CLK);
      #1;
    end
    drive(to_b, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic wait_cnt(input int n, input int lim, input string nm);
    int t = 0;
    while (txq.size() < n && t < lim) begin
      @(posedge CLK);
      #1;
      t++;
    end
    chk(nm, txq.size(), n);
  endtask

  typedef struct {
    logic av; logic [7:0] ad; logic al;
    logic bv; logic [7:0] bd; logic bl;
    logic tr;
    logic ev; logic [7:0] ed; logic ega; logic egb; logic ear; logic ebr; logic eto;
  } vec_t;

  function automatic vec_t mkv(logic av, logic [7:0] ad, logic al, logic bv, logic [7:0] bd,
                               logic bl, logic tr, logic ev, logic [7:0] ed, logic ega,
                               logic egb, logic ear, logic ebr, logic eto);
    vec_t v;
    v.av = av; v.ad = ad; v.al = al; v.bv = bv; v.bd = bd; v.bl = bl; v.tr = tr;
    v.ev = ev; v.ed = ed; v.ega = ega; v.egb = egb; v.ear = ear; v.ebr = ebr; v.eto = eto;
    return v;
  endfunction

  localparam int NV = 17;
  vec_t vt[NV];

  initial begin
    logic [7:0] exp_b;
    int first_k, pulses, n0;
    logic gb_at, ga21, waited, found;
    logic [7:0] td21;

    //           av    ad     al    bv    bd     bl    tr  | ev    ed     ga    gb    ar    br    to
    vt[0]  = mkv(1'b1, 8'h11, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    vt[1]  = mkv(1'b1, 8'h11, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    vt[2]  = mkv(1'b1, 8'h11, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    vt[3]  = mkv(1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vt[4]  = mkv(1'b1, 8'h33, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 8'hB5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    vt[5]  = mkv(1'b1, 8'h33, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 8'hB5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    vt[6]  = mkv(1'b1, 8'h33, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    vt[7]  = mkv(1'b1, 8'h33, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vt[8]  = mkv(1'b1, 8'h33, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    vt[9]  = mkv(1'b1, 8'h33, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    vt[10] = mkv(1'b1, 8'h33, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    vt[11] = mkv(1'b1, 8'h33, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    vt[12] = mkv(1'b1, 8'h44, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    vt[13] = mkv(1'b1, 8'h44, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h33, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    vt[14] = mkv(1'b1, 8'h44, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h44, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    vt[15] = mkv(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h44, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vt[16] = mkv(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h44, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset state
    RST_N = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    ser_auto = 1'b0; tx_ready_man = 1'b0; ser_flush = 1'b1; ser_gap = 10;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_tx_valid", bus.tx_valid, 0);
    chk("rst_tx_data", bus.tx_data, 8'h00);
    chk("rst_gnt", {bus.gnt_a, bus.gnt_b}, 0);
    chk("rst_ready", {bus.a_ready, bus.b_ready}, 0);
    chk("rst_timeout", bus.timeout, 0);

    // Cycle-vector table: grants, rr alternation, single-byte packets, tx back-pressure
    do_reset();
    for (int i = 0; i < NV; i++) begin
      drive(1'b0, vt[i].av, vt[i].ad, vt[i].al);
      drive(1'b1, vt[i].bv, vt[i].bd, vt[i].bl);
      tx_ready_man = vt[i].tr;
      @(posedge CLK);
      #1;
      chk($sformatf("vec%0d_tx_valid", i), bus.tx_valid, vt[i].ev);
      chk($sformatf("vec%0d_tx_data", i), bus.tx_data, vt[i].ed);
      chk($sformatf("vec%0d_gnt_a", i), bus.gnt_a, vt[i].ega);
      chk($sformatf("vec%0d_gnt_b", i), bus.gnt_b, vt[i].egb);
      chk($sformatf("vec%0d_a_ready", i), bus.a_ready, vt[i].ear);
      chk($sformatf("vec%0d_b_ready", i), bus.b_ready, vt[i].ebr);
      chk($sformatf("vec%0d_timeout", i), bus.timeout, vt[i].eto);
    end

    // Single 3-byte A packet through a serializer busy 10 cycles per byte
    do_reset();
    ser_auto = 1'b1; ser_gap = 10;
    fork
      send_pkt(1'b0, 8'h01, 8'h02, 8'h03, 3);
      wait_cnt(4, 300, "single_count");
    join
    chk("single_gnt_a_after", bus.gnt_a, 0);
    if (txq.size() == 4) begin
      chk("single_b0", txq[0], 8'hA5);
      chk("single_b1", txq[1], 8'h01);
      chk("single_b2", txq[2], 8'h02);
      chk("single_b3", txq[3], 8'h03);
      for (int i = 0; i < 4; i++) chk($sformatf("single_gnt%0d", i), gq[i], 2'b10);
    end

    // Contention: both requesters stream 2-byte packets back to back
    do_reset();
    ser_auto = 1'b1; ser_gap = 2;
    fork
      for (int p = 0; p < 3; p++) send_pkt(1'b0, 8'(8'h10 + 2 * p), 8'(8'h11 + 2 * p), 8'h00, 2);
      for (int p = 0; p < 3; p++) send_pkt(1'b1, 8'(8'h20 + 2 * p), 8'(8'h21 + 2 * p), 8'h00, 2);
    join
    wait_cnt(18, 300, "cont_count");
    if (txq.size() == 18) begin
      for (int k = 0; k < 6; k++) begin
        for (int j = 0; j < 3; j++) begin
          if (j == 0) exp_b = (k % 2 == 0) ? 8'hA5 : 8'hB5;
          else exp_b = 8'(((k % 2 == 0) ? 8'h10 : 8'h20) + 2 * (k / 2) + j - 1);
          chk($sformatf("cont_byte%0d", 3 * k + j), txq[3 * k + j], exp_b);
          chk($sformatf("cont_gnt%0d", 3 * k + j), gq[3 * k + j], (k % 2 == 0) ? 2'b10 : 2'b01);
        end
      end
    end

    // Back-pressure on a payload byte: everything frozen, timer must not run
    do_reset();
    drive(1'b0, 1'b1, 8'h5A, 1'b1);
    @(posedge CLK); #1;
    tx_ready_man = 1'b1;
    @(posedge CLK); #1;
    tx_ready_man = 1'b0;
    @(posedge CLK); #1;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    for (int c = 0; c < 50; c++) begin
      chk("bp_tx_valid", bus.tx_valid, 1);
      chk("bp_tx_data", bus.tx_data, 8'h5A);
      chk("bp_a_ready", bus.a_ready, 0);
      chk("bp_timeout", bus.timeout, 0);
      @(posedge CLK); #1;
    end
    tx_ready_man = 1'b1;
    @(posedge CLK); #1;
    chk("bp_release_gnt_a", bus.gnt_a, 0);
    chk("bp_release_timeout", bus.timeout, 0);

    // Abandon: B stalls after one non-last byte; TIMEOUT=20
    do_reset();
    tx_ready_man = 1'b1;
    drive(1'b1, 1'b1, 8'h77, 1'b0);
    @(posedge CLK); #1;
    chk("ab_hdr", bus.tx_data, 8'hB5);
    chk("ab_gnt_b", bus.gnt_b, 1);
    @(posedge CLK); #1;
    chk("ab_b_ready", bus.b_ready, 1);
    @(posedge CLK); #1;
    chk("ab_byte", bus.tx_data, 8'h77);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b1, 8'h12, 1'b1);
    @(posedge CLK); #1;
    chk("ab_accepted", bus.tx_valid, 0);
    first_k = 0; pulses = 0; gb_at = 1'b1; ga21 = 1'b0; td21 = 8'h00;
    for (int k = 1; k <= 22; k++) begin
      @(posedge CLK); #1;
      if (bus.timeout) begin
        pulses++;
        if (first_k == 0) begin
          first_k = k;
          gb_at = bus.gnt_b;
        end
      end
      if (k == 21) begin
        ga21 = bus.gnt_a;
        td21 = bus.tx_data;
      end
    end
    chk("ab_pulses", pulses, 1);
    chk("ab_pulse_cycle", first_k, 20);
    chk("ab_gnt_b_at_pulse", gb_at, 0);
    chk("ab_next_gnt_a", ga21, 1);
    chk("ab_next_hdr", td21, 8'hA5);
    drive(1'b0, 1'b0, 8'h00, 1'b0);

    // Reset during an A payload byte, then a B request after release
    do_reset();
    ser_auto = 1'b1; ser_gap = 10;
    drive(1'b0, 1'b1, 8'h31, 1'b0);
    found = 1'b0;
    for (int t = 0; t < 200 && !found; t++) begin
      @(posedge CLK); #1;
      if (bus.tx_valid && bus.tx_data == 8'h31) found = 1'b1;
    end
    chk("rp_payload_seen", found, 1);
    @(negedge CLK); #2;
    RST_N = 1'b0;
    #1;
    chk("rp_tx_valid", bus.tx_valid, 0);
    chk("rp_gnt_a", bus.gnt_a, 0);
    chk("rp_a_ready", bus.a_ready, 0);
    n0 = txq.size();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b1, 1'b1, 8'h41, 1'b1);
    @(negedge CLK);
    RST_N = 1'b1;
    waited = 1'b0;
    for (int t = 0; t < 200 && txq.size() <= n0; t++) begin
      @(posedge CLK); #1;
      if (bus.tx_valid && !bus.tx_ready) waited = 1'b1;
    end
    chk("rp_new_byte", int'(txq.size() > n0), 1);
    chk("rp_hdr_waited", waited, 1);
    if (txq.size() > n0) chk("rp_first_hdr", txq[n0], 8'hB5);
    drive(1'b1, 1'b0, 8'h00, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
